// File: rtl/stdp_train_ctrl_if.sv
// Control/observation bundle between the STDP training sequencer and its driver.
// The master side starts sessions and returns the synapse weight; the slave side is the sequencer.
interface stdp_train_ctrl_if #(
    parameter int WEIGHT_W = 8,
    parameter int CNT_W    = 8
);
    logic                start;
    logic                abort;
    logic [CNT_W-1:0]    train_pairs;
    logic [CNT_W-1:0]    test_pulses;
    logic [3:0]          gap_cycles;
    logic [WEIGHT_W-1:0] weight;
    logic                pre_spike;
    logic                post_spike;
    logic                learning_enable;
    logic                store_final;
    logic [WEIGHT_W-1:0] final_weight;
    logic                busy;
    logic                done;
    logic                drift_err;

    modport master (
        output start, abort, train_pairs, test_pulses, gap_cycles, weight,
        input  pre_spike, post_spike, learning_enable, store_final,
               final_weight, busy, done, drift_err
    );

    modport slave (
        input  start, abort, train_pairs, test_pulses, gap_cycles, weight,
        output pre_spike, post_spike, learning_enable, store_final,
               final_weight, busy, done, drift_err
    );
endinterface

// File: rtl/stdp_train_ctrl.sv
// STDP training sequencer: paired pre/post spikes with learning on, then frozen pre-only
// probes that watch for weight drift, then a weight commit and capture.
module stdp_train_ctrl #(
    parameter int WEIGHT_W = 8,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    stdp_train_ctrl_if.slave  bus
);
    typedef enum logic [3:0] {
        IDLE, TRAIN_PULSE, TRAIN_GAP, FREEZE, TEST_PULSE, TEST_GAP, STORE, CAPTURE, DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t              state, state_d;
    logic [CNT_W-1:0]    pairs_lat, tests_lat;
    logic [3:0]          gap_lat;
    logic [CNT_W-1:0]    pair_cnt, pair_cnt_d;
    logic [CNT_W-1:0]    test_cnt, test_cnt_d;
    logic [3:0]          gap_cnt, gap_cnt_d;
    logic [WEIGHT_W-1:0] ref_weight;
    logic                accept;

    assign accept = (state == IDLE) && bus.start;

    // Counters are compared after increment, so a full-scale count ends exactly at 2^CNT_W-1.
    always_comb begin
        state_d    = state;
        pair_cnt_d = pair_cnt;
        test_cnt_d = test_cnt;
        gap_cnt_d  = gap_cnt;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_d    = (bus.train_pairs == '0) ? FREEZE : TRAIN_PULSE;
                    pair_cnt_d = '0;
                    test_cnt_d = '0;
                    gap_cnt_d  = '0;
                end
            end
            TRAIN_PULSE: begin
                pair_cnt_d = pair_cnt + CNT_ONE;
                gap_cnt_d  = '0;
                if (gap_lat != '0)
                    state_d = TRAIN_GAP;
                else
                    state_d = (pair_cnt + CNT_ONE == pairs_lat) ? FREEZE : TRAIN_PULSE;
            end
            TRAIN_GAP: begin
                if (gap_cnt == gap_lat - 4'd1)
                    state_d = (pair_cnt == pairs_lat) ? FREEZE : TRAIN_PULSE;
                else
                    gap_cnt_d = gap_cnt + 4'd1;
            end
            FREEZE: state_d = (tests_lat == '0) ? STORE : TEST_PULSE;
            TEST_PULSE: begin
                test_cnt_d = test_cnt + CNT_ONE;
                gap_cnt_d  = '0;
                if (gap_lat != '0)
                    state_d = TEST_GAP;
                else
                    state_d = (test_cnt + CNT_ONE == tests_lat) ? STORE : TEST_PULSE;
            end
            TEST_GAP: begin
                if (gap_cnt == gap_lat - 4'd1)
                    state_d = (test_cnt == tests_lat) ? STORE : TEST_PULSE;
                else
                    gap_cnt_d = gap_cnt + 4'd1;
            end
            STORE:   state_d = CAPTURE;
            CAPTURE: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state != IDLE && bus.abort)
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pairs_lat <= '0;
            tests_lat <= '0;
            gap_lat   <= '0;
            pair_cnt  <= '0;
            test_cnt  <= '0;
            gap_cnt   <= '0;
        end else begin
            state    <= state_d;
            pair_cnt <= pair_cnt_d;
            test_cnt <= test_cnt_d;
            gap_cnt  <= gap_cnt_d;
            if (accept) begin
                pairs_lat <= bus.train_pairs;
                tests_lat <= bus.test_pulses;
                gap_lat   <= bus.gap_cycles;
            end
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pre_spike       <= 1'b0;
            bus.post_spike      <= 1'b0;
            bus.learning_enable <= 1'b1;
            bus.store_final     <= 1'b0;
            bus.busy            <= 1'b0;
            bus.done            <= 1'b0;
            bus.drift_err       <= 1'b0;
            bus.final_weight    <= '0;
            ref_weight          <= '0;
        end else begin
            bus.pre_spike       <= (state_d == TRAIN_PULSE) || (state_d == TEST_PULSE);
            bus.post_spike      <= (state_d == TRAIN_PULSE);
            bus.learning_enable <= (state_d == IDLE) || (state_d == TRAIN_PULSE) ||
                                   (state_d == TRAIN_GAP);
            bus.store_final     <= (state_d == STORE);
            bus.busy            <= (state_d != IDLE);
            bus.done            <= (state_d == DONE);
            if (state == FREEZE)
                ref_weight <= bus.weight;
            if (state == CAPTURE && state_d == DONE)
                bus.final_weight <= bus.weight;
            if (accept)
                bus.drift_err <= 1'b0;
            else if ((state == TEST_PULSE || state == TEST_GAP) && bus.weight != ref_weight)
                bus.drift_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_stdp_train_ctrl.sv
// Bench for stdp_train_ctrl: directed session table, random sessions and a mid-session reset,
// all checked cycle by cycle against a phase-timeline model of a training session.
module tb_stdp_train_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] model_final = '0;

    stdp_train_ctrl_if #(.WEIGHT_W(8), .CNT_W(8)) bus ();
    stdp_train_ctrl #(.WEIGHT_W(8), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef enum {PH_TP, PH_TG, PH_FR, PH_XP, PH_XG, PH_ST, PH_CA, PH_DN} phase_t;

    typedef struct {
        int         pairs, tests, gap;
        logic [7:0] w0, w1;
        int         chg, abort_at;
        logic [7:0] exp_final;
        logic       exp_drift;
    } vec_t;

    // Packed view: {pre, post, learning_enable, store_final, busy, done, drift_err}
    function automatic logic [6:0] outs();
        return {bus.pre_spike, bus.post_spike, bus.learning_enable, bus.store_final,
                bus.busy, bus.done, bus.drift_err};
    endfunction

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic run_session(input int pairs, input int tests, input int gap,
                               input logic [7:0] w0, input logic [7:0] w1,
                               input int chg, input int abort_at, input bit rnd_start);
        phase_t     ph[$];
        logic [7:0] refw, wk;
        logic [6:0] exp;
        logic       drift_m;
        bit         aborted, busy_cycle;
        int         len;
        for (int i = 0; i < pairs; i++) begin
            ph.push_back(PH_TP);
            for (int g = 0; g < gap; g++) ph.push_back(PH_TG);
        end
        ph.push_back(PH_FR);
        refw = (pairs * (1 + gap) + 1 >= chg) ? w1 : w0;
        for (int i = 0; i < tests; i++) begin
            ph.push_back(PH_XP);
            for (int g = 0; g < gap; g++) ph.push_back(PH_XG);
        end
        ph.push_back(PH_ST);
        ph.push_back(PH_CA);
        ph.push_back(PH_DN);
        len = ph.size();

        bus.train_pairs = 8'(pairs);
        bus.test_pulses = 8'(tests);
        bus.gap_cycles  = 4'(gap);
        bus.weight      = (chg <= 0) ? w1 : w0;
        bus.abort       = 1'b0;
        bus.start       = 1'b1;
        drift_m = 1'b0;
        aborted = 1'b0;
        for (int k = 1; k <= len + 1; k++) begin
            @(negedge clk);
            busy_cycle = !aborted && (k <= len);
            if (busy_cycle) begin
                phase_t p;
                p = ph[k-1];
                if (p == PH_DN) model_final = (k - 1 >= chg) ? w1 : w0;
                exp = {p == PH_TP || p == PH_XP, p == PH_TP, p == PH_TP || p == PH_TG,
                       p == PH_ST, 1'b1, p == PH_DN, drift_m};
            end else begin
                exp = {5'b00100, 1'b0, drift_m};
            end
            chk("outputs", k, 32'(outs()), 32'(exp));
            chk("final_weight", k, 32'(bus.final_weight), 32'(model_final));
            wk = (k >= chg) ? w1 : w0;
            if (busy_cycle && (ph[k-1] == PH_XP || ph[k-1] == PH_XG) && wk != refw)
                drift_m = 1'b1;
            bus.weight = wk;
            bus.abort  = busy_cycle && (k == abort_at);
            bus.start  = rnd_start && busy_cycle && ($urandom_range(0, 3) == 0);
            if (bus.abort) aborted = 1'b1;
        end
        @(negedge clk);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("idle_after", len + 2, 32'(outs()), 32'({5'b00100, 1'b0, drift_m}));
    endtask

    vec_t tbl[9];

    initial begin
        tbl[0] = '{3, 2, 1, 8'h40, 8'h40, 1000, -1, 8'h40, 1'b0};
        tbl[1] = '{4, 0, 0, 8'h40, 8'h40, 1000, -1, 8'h40, 1'b0};
        tbl[2] = '{0, 0, 0, 8'h55, 8'h55, 1000, -1, 8'h55, 1'b0};
        tbl[3] = '{1, 2, 2, 8'h40, 8'h41, 6,    -1, 8'h41, 1'b1};
        tbl[4] = '{2, 1, 0, 8'h33, 8'h33, 1000, -1, 8'h33, 1'b0};
        tbl[5] = '{3, 2, 1, 8'h40, 8'h40, 1000, 4,  8'h33, 1'b0};
        tbl[6] = '{255, 1, 0, 8'h7a, 8'h7a, 1000, -1, 8'h7a, 1'b0};
        tbl[7] = '{1, 1, 15, 8'h12, 8'h12, 1000, -1, 8'h12, 1'b0};
        tbl[8] = '{2, 3, 0, 8'h20, 8'h21, 2,    -1, 8'h21, 1'b0};

        rst_n = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.train_pairs = '0;
        bus.test_pulses = '0; bus.gap_cycles = '0; bus.weight = '0;
        @(negedge clk);
        chk("reset_outputs", 0, 32'(outs()), 32'(7'b0010000));
        chk("reset_final", 0, 32'(bus.final_weight), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_idle", 0, 32'(outs()), 32'(7'b0010000));

        foreach (tbl[i]) begin
            run_session(tbl[i].pairs, tbl[i].tests, tbl[i].gap, tbl[i].w0, tbl[i].w1,
                        tbl[i].chg, tbl[i].abort_at, i == 5);
            chk($sformatf("tbl%0d_final", i), 0, 32'(bus.final_weight), 32'(tbl[i].exp_final));
            chk($sformatf("tbl%0d_drift", i), 0, 32'(bus.drift_err), 32'(tbl[i].exp_drift));
        end

        for (int r = 0; r < 25; r++) begin
            int         pr, ts, gp, len, ab;
            logic [7:0] a, b;
            pr  = $urandom_range(0, 6);
            ts  = $urandom_range(0, 5);
            gp  = $urandom_range(0, 3);
            len = pr * (1 + gp) + ts * (1 + gp) + 4;
            a   = 8'($urandom);
            b   = ($urandom_range(0, 1) == 1) ? a + 8'd1 : a;
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len)) : -1;
            run_session(pr, ts, gp, a, b, int'($urandom_range(0, len + 1)), ab, 1'b1);
        end

        // Asynchronous reset in the middle of a test pulse.
        begin
            bit found = 1'b0;
            bus.train_pairs = 8'd2; bus.test_pulses = 8'd3; bus.gap_cycles = 4'd2;
            bus.weight = 8'h66; bus.start = 1'b1;
            for (int k = 0; k < 60 && !found; k++) begin
                @(negedge clk);
                bus.start = 1'b0;
                if (bus.pre_spike && !bus.post_spike && bus.busy) found = 1'b1;
            end
            checks++;
            if (!found) begin
                errors++;
                $display("FAIL test_pulse_wait cycle 60: got none expected pre-only pulse");
            end
            rst_n = 1'b0;
            #1;
            chk("async_reset_outputs", 0, 32'(outs()), 32'(7'b0010000));
            chk("async_reset_final", 0, 32'(bus.final_weight), 32'h0);
            model_final = '0;
            @(negedge clk);
            chk("reset_no_done", 0, 32'(outs()), 32'(7'b0010000));
            rst_n = 1'b1;
            @(negedge clk);
            run_session(2, 2, 1, 8'h5c, 8'h5c, 1000, -1, 1'b0);
            chk("post_reset_final", 0, 32'(bus.final_weight), 32'h5c);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
